uart_fifo_param: RTL and testbench

Parametrised synchronous FIFO for the UART transmit and receive paths. It is the successor to the fixed 16x8 transmit FIFO and adds:
- configurable data width and depth;
- a fill-level count and programmable almost-full/almost-empty flags;
- a synchronous flush and sticky overflow/underflow error flags;
- protection against reads on an empty FIFO.
It sits between the bus-side UART register interface and the UART shifter, in either direction.

---
 rtl/uart_fifo_param_if.sv | 33 +++
 rtl/uart_fifo_param.sv | 109 ++++++++++
 tb/tb_uart_fifo_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_param_if.sv
// Bus-side bundle for uart_fifo_param.
//   master : producer/consumer driving clear, fifoWe, fifoRe, dataIn, errorClear
//   slave  : the FIFO, returning dataOut, status flags, fillLevel and error flags
interface uart_fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) ();
  logic                  clear;
  logic                  fifoWe;
  logic                  fifoRe;
  logic                  errorClear;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic                  almostFull;
  logic                  almostEmpty;
  logic [ADDR_WIDTH:0]   fillLevel;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, fifoWe, fifoRe, errorClear, dataIn,
    input  dataOut, fifoEmpty, fifoFull, almostFull, almostEmpty,
           fillLevel, overflow, underflow
  );

  modport slave (
    input  clear, fifoWe, fifoRe, errorClear, dataIn,
    output dataOut, fifoEmpty, fifoFull, almostFull, almostEmpty,
           fillLevel, overflow, underflow
  );
endinterface

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous first-word fall-through FIFO for the UART TX/RX
// paths, with fill level, almost-full/empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   fifo  : uart_fifo_param_if.slave (requests in, data/status out)
module uart_fifo_param #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDR_WIDTH         = 4,
  parameter int unsigned ALMOST_FULL_LEVEL  = 12,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 4
) (
  input  logic             clock,
  input  logic             reset,
  uart_fifo_param_if.slave fifo
);

  localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_LVL    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL    = ALMOST_EMPTY_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wrPtr, wrPtrNext;
  logic [ADDR_WIDTH-1:0] rdPtr, rdPtrNext;
  logic [ADDR_WIDTH:0]   level, levelNext;
  logic                  emptyQ, fullQ, almostFullQ, almostEmptyQ;
  logic                  overflowQ, underflowQ;
  logic                  overflowNext, underflowNext;
  logic                  wrAccept, rdAccept, dropWrite, ignoredRead;

  // A simultaneous read frees a slot on a full FIFO, but a simultaneous
  // write never makes an empty FIFO readable.
  always_comb begin
    wrAccept    = fifo.fifoWe & (~fullQ | fifo.fifoRe);
    rdAccept    = fifo.fifoRe & ~emptyQ;
    dropWrite   = fifo.fifoWe & fullQ & ~fifo.fifoRe;
    ignoredRead = fifo.fifoRe & emptyQ;
  end

  always_comb begin
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    levelNext     = level;
    overflowNext  = overflowQ;
    underflowNext = underflowQ;
    if (fifo.clear) begin
      wrPtrNext     = '0;
      rdPtrNext     = '0;
      levelNext     = '0;
      overflowNext  = 1'b0;
      underflowNext = 1'b0;
    end else begin
      if (wrAccept) wrPtrNext = wrPtr + 1'b1;
      if (rdAccept) rdPtrNext = rdPtr + 1'b1;
      unique case ({wrAccept, rdAccept})
        2'b10:   levelNext = level + 1'b1;
        2'b01:   levelNext = level - 1'b1;
        default: levelNext = level;
      endcase
      // A new error in the same cycle as errorClear keeps the flag set.
      overflowNext  = dropWrite   | (overflowQ  & ~fifo.errorClear);
      underflowNext = ignoredRead | (underflowQ & ~fifo.errorClear);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      level        <= '0;
      emptyQ       <= 1'b1;
      fullQ        <= 1'b0;
      almostEmptyQ <= 1'b1;
      almostFullQ  <= 1'b0;
      overflowQ    <= 1'b0;
      underflowQ   <= 1'b0;
    end else begin
      wrPtr        <= wrPtrNext;
      rdPtr        <= rdPtrNext;
      level        <= levelNext;
      emptyQ       <= (levelNext == '0);
      fullQ        <= (levelNext == DEPTH_LVL);
      almostEmptyQ <= (levelNext <= AE_LVL);
      almostFullQ  <= (levelNext >= AF_LVL);
      overflowQ    <= overflowNext;
      underflowQ   <= underflowNext;
    end
  end

  // Storage carries no reset; writes are held off while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset && !fifo.clear && wrAccept) begin
      mem[wrPtr] <= fifo.dataIn;
    end
  end

  assign fifo.dataOut     = mem[rdPtr];
  assign fifo.fifoEmpty   = emptyQ;
  assign fifo.fifoFull    = fullQ;
  assign fifo.almostFull  = almostFullQ;
  assign fifo.almostEmpty = almostEmptyQ;
  assign fifo.fillLevel   = level;
  assign fifo.overflow    = overflowQ;
  assign fifo.underflow   = underflowQ;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Self-checking bench for uart_fifo_param: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_uart_fifo_param;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          AFL   = 12;
  localparam int          AEL   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ALMOST_FULL_LEVEL(AFL),
    .ALMOST_EMPTY_LEVEL(AEL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fifo(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: contents as a queue plus the two sticky error bits.
  logic [7:0] mq[$];
  logic       mOvf = 1'b0;
  logic       mUnf = 1'b0;

  typedef struct {
    logic       we, re, clr, eclr;
    logic [7:0] din;
    int         lvl;
    logic       ovf, unf, chkD;
    logic [7:0] dOut;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(logic we, logic re, logic clr, logic eclr,
                                 logic [7:0] din, int lvl, logic ovf, logic unf,
                                 logic chkD, logic [7:0] dOut);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.eclr = eclr; v.din = din;
    v.lvl = lvl; v.ovf = ovf; v.unf = unf; v.chkD = chkD; v.dOut = dOut;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Flags follow directly from the level by their definitions.
  task automatic checkConst(input string tag, input int lvl, input logic ovf,
                            input logic unf, input logic chkD, input logic [7:0] d);
    chk({tag, ".level"}, int'(bus.fillLevel), lvl);
    chk({tag, ".empty"}, int'(bus.fifoEmpty), int'(lvl == 0));
    chk({tag, ".full"}, int'(bus.fifoFull), int'(lvl == DEPTH));
    chk({tag, ".almostFull"}, int'(bus.almostFull), int'(lvl >= AFL));
    chk({tag, ".almostEmpty"}, int'(bus.almostEmpty), int'(lvl <= AEL));
    chk({tag, ".overflow"}, int'(bus.overflow), int'(ovf));
    chk({tag, ".underflow"}, int'(bus.underflow), int'(unf));
    if (chkD) chk({tag, ".dataOut"}, int'(bus.dataOut), int'(d));
  endtask

  task automatic checkModel(input string tag);
    logic [7:0] head;
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    checkConst(tag, mq.size(), mOvf, mUnf, mq.size() > 0, head);
  endtask

  task automatic modelStep(input logic we, input logic re, input logic clr,
                           input logic eclr, input logic [7:0] din);
    bit full, empty, wrOk, rdOk;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (clr) begin
      mq.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      wrOk = we && (!full || re);
      rdOk = re && !empty;
      if (rdOk) void'(mq.pop_front());
      if (wrOk) mq.push_back(din);
      mOvf = (we && full && !re) || (mOvf && !eclr);
      mUnf = (re && empty) || (mUnf && !eclr);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic clr,
                       input logic eclr, input logic [7:0] din);
    bus.fifoWe     = we;
    bus.fifoRe     = re;
    bus.clear      = clr;
    bus.errorClear = eclr;
    bus.dataIn     = din;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic we, input logic re, input logic clr,
                      input logic eclr, input logic [7:0] din);
    drive(we, re, clr, eclr, din);
    @(posedge clock);
    modelStep(we, re, clr, eclr, din);
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit we, re, clr, eclr;
    int wp, rp;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    checkConst("reset", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    // Directed table: fill, overflow, drain, underflow, empty write+read.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mkVec(1, 0, 0, 0, 8'(8'h11 + i), i + 1, 0, 0, 1, 8'h11));
    tbl.push_back(mkVec(1, 0, 0, 0, 8'hAA, 16, 1, 0, 1, 8'h11));
    for (int j = 0; j < 16; j++)
      tbl.push_back(mkVec(0, 1, 0, 0, 8'h00, 15 - j, 1, 0, j < 15, 8'(8'h12 + j)));
    tbl.push_back(mkVec(0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mkVec(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mkVec(1, 1, 0, 0, 8'h5A, 1, 0, 1, 1, 8'h5A));
    tbl.push_back(mkVec(0, 0, 0, 0, 8'h00, 1, 0, 1, 1, 8'h5A));
    tbl.push_back(mkVec(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00));

    foreach (tbl[k]) begin
      step(tbl[k].we, tbl[k].re, tbl[k].clr, tbl[k].eclr, tbl[k].din);
      checkConst($sformatf("vec%0d", k), tbl[k].lvl, tbl[k].ovf, tbl[k].unf,
                 tbl[k].chkD, tbl[k].dOut);
    end

    // Full with simultaneous read/write: level holds, pointers wrap.
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 8'(8'hC0 + i));
      checkModel("t4.fill");
    end
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 0, 8'(8'h60 + k));
      checkModel("t4.rw");
    end
    chk("t4.head", int'(bus.dataOut), 8'h64);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 8'h00);
      checkModel("t4.drain");
    end

    // Clear at level 9 with overflow set, together with a write.
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h80 + i));
    step(1, 0, 0, 0, 8'hEE);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 8'h00);
    checkConst("t5.pre", 9, 1'b1, 1'b0, 1'b1, 8'h87);
    step(1, 0, 1, 0, 8'hEE);
    checkConst("t5.clr", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h90 + i));
    step(1, 0, 0, 0, 8'h98);
    checkModel("t5.drop");
    step(1, 0, 0, 1, 8'h99);
    chk("t5.ovfHold", int'(bus.overflow), 1);
    checkModel("t5.eclrDrop");
    step(0, 0, 0, 1, 8'h00);
    checkConst("t5.eclr", 16, 1'b0, 1'b0, 1'b1, 8'h90);

    // Asynchronous reset mid-burst at level 7.
    step(0, 0, 1, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    checkConst("t6.pre", 7, 1'b0, 1'b1, 1'b1, 8'h40);
    drive(0, 0, 0, 0, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    checkConst("t6.async", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    mq.delete();
    mOvf = 1'b0;
    mUnf = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step(1, 0, 0, 0, 8'h3C);
    checkConst("t6.post", 1, 1'b0, 1'b0, 1'b1, 8'h3C);

    // Randomized traffic in write-heavy, balanced and read-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      wp   = (n < 1000) ? 75 : (n < 2000) ? 50 : 30;
      rp   = (n < 1000) ? 30 : (n < 2000) ? 50 : 75;
      we   = ($urandom_range(99) < wp);
      re   = ($urandom_range(99) < rp);
      clr  = ($urandom_range(127) == 0);
      eclr = ($urandom_range(15) == 0);
      d    = 8'($urandom);
      step(we, re, clr, eclr, d);
      checkModel("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
